// File: rtl/alu4_ctrl.sv
// Sequencing front-end for the 4-bit ALU: valid/ready request intake, single-cycle
// logic/add/sub/pass datapath, multi-cycle shift-add multiply, and a held output register.
module alu4_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 err
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PASS = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   acc, acc_nx;
  logic [RW-1:0]   mcand, mcand_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [RW-1:0]   result_nx;
  logic            carry_nx, err_nx;

  // Single-cycle datapath, evaluated on the operands present at acceptance.
  logic [RW-1:0]   alu_res;
  logic            alu_carry;
  logic            alu_err;
  logic [WIDTH:0]  add_sum;
  logic [RW-1:0]   acc_sum;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    unique case (op_t'(op))
      OP_AND:  alu_res[WIDTH-1:0] = a & b;
      OP_OR:   alu_res[WIDTH-1:0] = a | b;
      OP_XOR:  alu_res[WIDTH-1:0] = a ^ b;
      OP_ADD: begin
        alu_res[WIDTH:0] = add_sum;
        alu_carry        = add_sum[WIDTH];
      end
      OP_SUB: begin
        alu_res[WIDTH-1:0] = a - b;
        alu_carry          = (a < b);
      end
      OP_PASS: alu_res[WIDTH-1:0] = a;
      OP_ILL:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    cnt_nx    = cnt;
    result_nx = result;
    carry_nx  = carry;
    err_nx    = err;

    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (op_t'(op) == OP_MUL) begin
            acc_nx    = '0;
            mcand_nx  = {{WIDTH{1'b0}}, a};
            mplier_nx = b;
            cnt_nx    = '0;
            state_nx  = S_MUL;
          end else begin
            result_nx = alu_res;
            carry_nx  = alu_carry;
            err_nx    = alu_err;
            state_nx  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_nx    = acc_sum;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          // Last iteration folds its partial product straight into the output register.
          result_nx = acc_sum;
          carry_nx  = 1'b0;
          err_nx    = 1'b0;
          cnt_nx    = '0;
          state_nx  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      carry  <= carry_nx;
      err    <= err_nx;
      if (state_nx == S_DONE && state != S_DONE) zero <= (result_nx == '0);
    end
  end

endmodule

// File: tb/tb_alu4_ctrl.sv
// Directed testbench for alu4_ctrl: reset, each op class, multiply latency,
// back-pressure, reset abort mid-multiply and illegal opcode.
module tb_alu4_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       result;
  logic             carry, zero, err;

  int total = 0;
  int bad   = 0;

  alu4_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one request; returns 1 cycle after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin cyc(); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  // Count cycles from acceptance until out_valid; lat=1 means cycle k+1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin cyc(); lat++; end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL valid_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL consume: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    cyc(); cyc();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    total++;
    if ({out_valid, result, carry, zero, err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: ov=%0b res=%h c=%0b z=%0b e=%0b required all 0",
               out_valid, result, carry, zero, err);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_in_ready: got %0b required 1", in_ready);
    end
    cyc();
    total++;
    if (out_valid !== 1'b0 || result !== 8'h00) begin
      bad++; $display("FAIL idle_outputs: ov=%0b res=%h required 0 00", out_valid, result);
    end
  endtask

  task automatic test_add_sub_and();
    int lat;
    issue(3'b011, 4'h9, 4'h8);
    wait_valid(lat);
    total++;
    if (lat !== 1 || result !== 8'h11 || carry !== 1'b1 || zero !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL add_9_8: lat=%0d res=%h c=%0b z=%0b e=%0b required 1 11 1 0 0",
               lat, result, carry, zero, err);
    end
    consume();

    issue(3'b100, 4'h3, 4'h5);
    wait_valid(lat);
    total++;
    if (lat !== 1 || result !== 8'h0E || carry !== 1'b1 || zero !== 1'b0) begin
      bad++;
      $display("FAIL sub_3_5: lat=%0d res=%h c=%0b z=%0b required 1 0e 1 0", lat, result, carry, zero);
    end
    consume();

    issue(3'b000, 4'hA, 4'h5);
    wait_valid(lat);
    total++;
    if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
      bad++;
      $display("FAIL and_a_5: res=%h z=%0b c=%0b required 00 1 0", result, zero, carry);
    end
    consume();

    issue(3'b100, 4'h7, 4'h2);
    wait_valid(lat);
    total++;
    if (result !== 8'h05 || carry !== 1'b0) begin
      bad++; $display("FAIL sub_7_2: res=%h c=%0b required 05 0", result, carry);
    end
    consume();
  endtask

  task automatic test_mul();
    int lat;
    issue(3'b101, 4'hF, 4'hF);
    wait_valid(lat);
    total++;
    if (lat !== 5 || result !== 8'hE1 || carry !== 1'b0 || zero !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL mul_15_15: lat=%0d res=%h c=%0b z=%0b e=%0b required 5 e1 0 0 0",
               lat, result, carry, zero, err);
    end
    consume();

    issue(3'b101, 4'h0, 4'h7);
    wait_valid(lat);
    total++;
    if (lat !== 5 || result !== 8'h00 || zero !== 1'b1) begin
      bad++; $display("FAIL mul_0_7: lat=%0d res=%h z=%0b required 5 00 1", lat, result, zero);
    end
    consume();

    issue(3'b101, 4'h6, 4'hB);
    wait_valid(lat);
    total++;
    if (result !== 8'h42) begin
      bad++; $display("FAIL mul_6_11: res=%h required 42", result);
    end
    consume();
  endtask

  task automatic test_back_pressure();
    int lat;
    int hold_bad;
    issue(3'b010, 4'hC, 4'hA);
    wait_valid(lat);
    in_valid = 1'b1; op = 3'b110; a = 4'h3; b = 4'h0;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 8'h06 || carry !== 1'b0 || zero !== 1'b0 ||
          err !== 1'b0 || in_ready !== 1'b0) hold_bad++;
      cyc();
    end
    total++;
    if (hold_bad != 0) begin
      bad++; $display("FAIL back_pressure_hold: unstable cycles=%0d required 0", hold_bad);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: ov=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    cyc();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'h03) begin
      bad++;
      $display("FAIL bp_second_request: ov=%0b res=%h required 1 03", out_valid, result);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int seen;
    issue(3'b101, 4'h5, 4'h3);
    cyc();
    rst = 1'b1;
    cyc();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00) begin
      bad++;
      $display("FAIL mid_mul_reset: in_ready=%0b ov=%0b res=%h required 0 0 00",
               in_ready, out_valid, result);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      cyc();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL aborted_mul_valid: out_valid cycles=%0d required 0", seen);
    end
    issue(3'b110, 4'h6, 4'h9);
    wait_valid(lat);
    total++;
    if (lat !== 1 || result !== 8'h06 || zero !== 1'b0) begin
      bad++; $display("FAIL pass_after_abort: lat=%0d res=%h z=%0b required 1 06 0", lat, result, zero);
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat;
    issue(3'b111, 4'hF, 4'hF);
    wait_valid(lat);
    total++;
    if (result !== 8'h00 || err !== 1'b1 || zero !== 1'b1 || carry !== 1'b0) begin
      bad++;
      $display("FAIL illegal_op: res=%h e=%0b z=%0b c=%0b required 00 1 1 0", result, err, zero, carry);
    end
    consume();
    issue(3'b001, 4'h1, 4'h2);
    wait_valid(lat);
    total++;
    if (result !== 8'h03 || err !== 1'b0 || zero !== 1'b0) begin
      bad++; $display("FAIL after_illegal_or: res=%h e=%0b z=%0b required 03 0 0", result, err, zero);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub_and();
    test_mul();
    test_back_pressure();
    test_reset_mid_mul();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
